// File: rtl/nic_msg_dispatcher_pkg.sv
// Shared message format, hint type codes and slot helpers for the NIC-to-CPU hint dispatcher.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package nic_msg_dispatcher_pkg;

  // Message word layout, most significant field first: {type, app_id, content}.
  localparam int APP_ID_WIDTH         = 2;
  localparam int NIC_MSG_TYPE_SIZE    = 4;
  localparam int NIC_MSG_CONTENT_SIZE = 16;
  localparam int NIC_MSG_WIDTH        = NIC_MSG_TYPE_SIZE + APP_ID_WIDTH + NIC_MSG_CONTENT_SIZE;

  localparam logic [NIC_MSG_TYPE_SIZE-1:0] NIC_MSG_SCALE_DOWN_HINT = 4'd1;
  localparam logic [NIC_MSG_TYPE_SIZE-1:0] NIC_MSG_CONG_HINT       = 4'd2;

  // Two hint kinds per app; kind 0 is scale-down, kind 1 is congestion.
  localparam int NIC_MSG_NUM_HINT_TYPES = 2;
  localparam int HINT_SCALE_DOWN        = 0;
  localparam int HINT_CONG              = 1;

  typedef struct packed {
    logic [NIC_MSG_TYPE_SIZE-1:0]    msg_type;
    logic [APP_ID_WIDTH-1:0]         app_id;
    logic [NIC_MSG_CONTENT_SIZE-1:0] content;
  } nic_msg_t;

  // Pending-store slot for a given app and hint kind.
  function automatic int hint_slot(input int app, input int kind);
    return app * NIC_MSG_NUM_HINT_TYPES + kind;
  endfunction

  // Round-robin position helper: (base + off) wrapped into [0, n).
  function automatic int wrap_slot(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

  function automatic logic [NIC_MSG_TYPE_SIZE-1:0] hint_type_code(input int kind);
    return (kind == HINT_CONG) ? NIC_MSG_CONG_HINT : NIC_MSG_SCALE_DOWN_HINT;
  endfunction

  function automatic logic is_hint_type(input logic [NIC_MSG_TYPE_SIZE-1:0] t);
    return (t == NIC_MSG_SCALE_DOWN_HINT) || (t == NIC_MSG_CONG_HINT);
  endfunction

endpackage

// File: rtl/nic_msg_fifo.sv
// Synchronous FIFO whose head word sits in a dedicated output register; exposes occupancy.
// Latency: a word pushed at edge N is visible on out_data after edge N (no same-cycle bypass).
// Backpressure: push is ignored while full (even if a pop happens that cycle); head holds while !out_ready.
//
// Ports: clk/rst (sync, active-high), push/push_data in, full out,
//        out_valid/out_ready/out_data head handshake, level = occupancy 0..DEPTH.
module nic_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == LW'(DEPTH));
  assign out_valid  = (count != '0);
  assign out_data   = head_q;
  assign level      = count;
  assign do_push    = push && !full;
  assign do_pop     = out_ready && out_valid;
  // DEPTH is a power of two, so the pointer wraps by plain overflow.
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      count <= count + LW'(do_push) - LW'(do_pop);

      // The head register mirrors mem[rd_ptr]. After a pop the next entry is
      // already in memory when at least two were stored; with exactly one
      // stored, the only candidate is the word being pushed right now.
      if (do_pop) begin
        if (count > LW'(1))  head_q <= mem[rd_ptr_nxt];
        else if (do_push)    head_q <= push_data;
        else                 head_q <= '0;
      end else if (!out_valid && do_push) begin
        head_q <= push_data;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nic_msg_dispatcher.sv
// Collects per-app hint strobes into a pending store, serialises them round-robin into one stream, and turns host acks into re-arm pulses.
// Latency: strobe at T -> pending at T+1 -> push at end of T+1 -> out_msg_valid at T+2; ack/rearm at T -> arm pulse at T+1.
// Backpressure: a full FIFO stalls the arbiter; pending slots simply wait, nothing is lost.
//
// Ports: clk/rst (sync, active-high); mon_msg_en/mon_msg per-monitor strobes and words;
//        out_msg_valid/out_msg_ready/out_msg host stream; host_ack_* and rearm_all in;
//        arm_cong_monitor/arm_scale_down_monitor one-cycle pulses; drop_count; fifo_level.
module nic_msg_dispatcher
  import nic_msg_dispatcher_pkg::*;
#(
  parameter int NUM_APPS   = 2**APP_ID_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_APPS-1:0]               mon_msg_en,
  input  logic [NUM_APPS*NIC_MSG_WIDTH-1:0] mon_msg,
  output logic                              out_msg_valid,
  input  logic                              out_msg_ready,
  output logic [NIC_MSG_WIDTH-1:0]          out_msg,
  input  logic                              host_ack_valid,
  input  logic [APP_ID_WIDTH-1:0]           host_ack_app_id,
  input  logic [NIC_MSG_TYPE_SIZE-1:0]      host_ack_type,
  input  logic                              rearm_all,
  output logic [NUM_APPS-1:0]               arm_cong_monitor,
  output logic [NUM_APPS-1:0]               arm_scale_down_monitor,
  output logic [31:0]                       drop_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int NUM_SLOTS = NUM_APPS * NIC_MSG_NUM_HINT_TYPES;
  localparam int SW        = $clog2(NUM_SLOTS);
  localparam int DCW       = $clog2(NUM_APPS + 1);

  // Pending store, slot = 2*app + kind.
  logic [NUM_SLOTS-1:0]            pending;
  logic [NIC_MSG_CONTENT_SIZE-1:0] content [NUM_SLOTS];
  logic [SW-1:0]                   rr_ptr;

  nic_msg_t             mon_word [NUM_APPS];
  logic                 fifo_full;
  logic                 grant_vld;
  logic [SW-1:0]        grant_idx;
  nic_msg_t             push_word;
  logic [NUM_SLOTS-1:0] cap_set;
  logic [DCW-1:0]       drops;
  logic [32:0]          drop_sum;
  logic [NUM_APPS-1:0]  arm_cong_nxt;
  logic [NUM_APPS-1:0]  arm_sd_nxt;
  logic                 unused_mon_app_ids;

  always_comb begin
    unused_mon_app_ids = 1'b0;
    for (int i = 0; i < NUM_APPS; i++) begin
      mon_word[i] = nic_msg_t'(mon_msg[i*NIC_MSG_WIDTH +: NIC_MSG_WIDTH]);
      // The monitor's own app_id field is ignored; the strobe index is authoritative.
      unused_mon_app_ids = unused_mon_app_ids ^ (^mon_word[i].app_id);
    end
  end

  // Round-robin arbiter: scan from rr_ptr; iterating downward lets the slot
  // closest to rr_ptr be the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
        if (pending[wrap_slot(int'(rr_ptr), j, NUM_SLOTS)]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(wrap_slot(int'(rr_ptr), j, NUM_SLOTS));
        end
      end
    end
  end

  always_comb begin
    push_word.msg_type = hint_type_code(int'(grant_idx) % NIC_MSG_NUM_HINT_TYPES);
    push_word.app_id   = APP_ID_WIDTH'(int'(grant_idx) / NIC_MSG_NUM_HINT_TYPES);
    push_word.content  = content[grant_idx];
  end

  // Capture: a strobe onto a slot that is being granted this cycle is not a
  // duplicate -- the old content leaves through the FIFO and the new one stays.
  always_comb begin
    cap_set = '0;
    drops   = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      if (mon_msg_en[i]) begin
        if (!is_hint_type(mon_word[i].msg_type)) begin
          drops = drops + DCW'(1);
        end else begin
          for (int k = 0; k < NIC_MSG_NUM_HINT_TYPES; k++) begin
            if (mon_word[i].msg_type == hint_type_code(k)) begin
              if (pending[hint_slot(i, k)] &&
                  !(grant_vld && int'(grant_idx) == hint_slot(i, k))) begin
                drops = drops + DCW'(1);
              end else begin
                cap_set[hint_slot(i, k)] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_count} + 33'(drops);

  // Ack and rearm_all pulses are ORed; unknown ack types produce nothing.
  always_comb begin
    arm_cong_nxt = {NUM_APPS{rearm_all}};
    arm_sd_nxt   = {NUM_APPS{rearm_all}};
    if (host_ack_valid && (int'(host_ack_app_id) < NUM_APPS)) begin
      if (host_ack_type == NIC_MSG_CONG_HINT)
        arm_cong_nxt[host_ack_app_id] = 1'b1;
      else if (host_ack_type == NIC_MSG_SCALE_DOWN_HINT)
        arm_sd_nxt[host_ack_app_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending                <= '0;
      rr_ptr                 <= '0;
      drop_count             <= '0;
      arm_cong_monitor       <= '0;
      arm_scale_down_monitor <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (cap_set[s])
          pending[s] <= 1'b1;
        else if (grant_vld && int'(grant_idx) == s)
          pending[s] <= 1'b0;
      end
      if (grant_vld)
        rr_ptr <= SW'(wrap_slot(int'(grant_idx), 1, NUM_SLOTS));
      drop_count             <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      arm_cong_monitor       <= arm_cong_nxt;
      arm_scale_down_monitor <= arm_sd_nxt;
    end
  end

  // Content is only meaningful while the pending bit is set, so it is not reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (cap_set[s])
        content[s] <= mon_word[s / NIC_MSG_NUM_HINT_TYPES].content;
    end
  end

  nic_msg_fifo #(
    .WIDTH (NIC_MSG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_vld),
    .push_data (push_word),
    .full      (fifo_full),
    .out_valid (out_msg_valid),
    .out_ready (out_msg_ready),
    .out_data  (out_msg),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_nic_msg_dispatcher.sv
// Self-checking bench for nic_msg_dispatcher: directed steps followed by a random phase,
// every cycle compared against a queue-based reference model.
// Runs to completion on its own and prints one summary line.
module tb_nic_msg_dispatcher;
  import nic_msg_dispatcher_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int NSLOT = 2 * N;
  localparam int W     = NIC_MSG_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         mon_msg_en;
  logic [N*W-1:0]       mon_msg;
  logic                 out_msg_valid;
  logic                 out_msg_ready;
  logic [W-1:0]         out_msg;
  logic                 host_ack_valid;
  logic [1:0]           host_ack_app_id;
  logic [3:0]           host_ack_type;
  logic                 rearm_all;
  logic [N-1:0]         arm_cong_monitor;
  logic [N-1:0]         arm_scale_down_monitor;
  logic [31:0]          drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  nic_msg_dispatcher #(.NUM_APPS(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mon_msg_en             (mon_msg_en),
    .mon_msg                (mon_msg),
    .out_msg_valid          (out_msg_valid),
    .out_msg_ready          (out_msg_ready),
    .out_msg                (out_msg),
    .host_ack_valid         (host_ack_valid),
    .host_ack_app_id        (host_ack_app_id),
    .host_ack_type          (host_ack_type),
    .rearm_all              (rearm_all),
    .arm_cong_monitor       (arm_cong_monitor),
    .arm_scale_down_monitor (arm_scale_down_monitor),
    .drop_count             (drop_count),
    .fifo_level             (fifo_level)
  );

  // Reference model state.
  logic         m_pend [NSLOT];
  logic [15:0]  m_cont [NSLOT];
  int           m_rr;
  logic [W-1:0] m_q [$];
  longint       m_drop;
  logic [N-1:0] m_cong;
  logic [N-1:0] m_sd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slot_word(input int s, input logic [15:0] c);
    logic [3:0] t;
    t = (s % 2 == 1) ? NIC_MSG_CONG_HINT : NIC_MSG_SCALE_DOWN_HINT;
    return {t, 2'(s / 2), c};
  endfunction

  // One clock edge of the specified behaviour, using the inputs the DUT samples.
  task automatic model_edge();
    int           g;
    int           k;
    int           s;
    bit           full;
    bit           pop;
    logic [W-1:0] w;
    logic [NSLOT-1:0] newset;
    logic [15:0]  newc [NSLOT];
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) m_pend[i] = 1'b0;
      m_rr = 0;
      m_q.delete();
      m_drop = 0;
      m_cong = '0;
      m_sd   = '0;
      return;
    end
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() > 0) && out_msg_ready;
    g = -1;
    if (!full)
      for (int j = 0; j < NSLOT; j++)
        if (g < 0 && m_pend[(m_rr + j) % NSLOT]) g = (m_rr + j) % NSLOT;
    newset = '0;
    for (int a = 0; a < N; a++) begin
      newc[a*2] = '0; newc[a*2+1] = '0;
    end
    for (int a = 0; a < N; a++) begin
      if (mon_msg_en[a]) begin
        w = mon_msg[a*W +: W];
        if (w[W-1 -: 4] == NIC_MSG_SCALE_DOWN_HINT) k = 0;
        else if (w[W-1 -: 4] == NIC_MSG_CONG_HINT) k = 1;
        else k = -1;
        if (k < 0) m_drop++;
        else begin
          s = 2 * a + k;
          if (m_pend[s] && s != g) m_drop++;
          else begin
            newset[s] = 1'b1;
            newc[s]   = w[15:0];
          end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(slot_word(g, m_cont[g]));
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % NSLOT;
    end
    for (int i = 0; i < NSLOT; i++)
      if (newset[i]) begin
        m_pend[i] = 1'b1;
        m_cont[i] = newc[i];
      end
    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    m_cong = rearm_all ? '1 : '0;
    m_sd   = rearm_all ? '1 : '0;
    if (host_ack_valid) begin
      if (host_ack_type == NIC_MSG_CONG_HINT) m_cong[host_ack_app_id] = 1'b1;
      else if (host_ack_type == NIC_MSG_SCALE_DOWN_HINT) m_sd[host_ack_app_id] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", out_msg_valid, m_q.size() > 0);
    chk("level", fifo_level, m_q.size());
    if (m_q.size() > 0) chk("out_msg", out_msg, m_q[0]);
    chk("drop_count", drop_count, m_drop);
    chk("arm_cong", arm_cong_monitor, m_cong);
    chk("arm_sd", arm_scale_down_monitor, m_sd);
    mon_msg_en     = '0;
    host_ack_valid = 1'b0;
    rearm_all      = 1'b0;
  endtask

  // The monitor-supplied app_id field is randomised: the DUT must ignore it.
  task automatic strobe(input int app, input logic [3:0] typ, input logic [15:0] c);
    mon_msg_en[app] = 1'b1;
    mon_msg[app*W +: W] = {typ, 2'($urandom), c};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int           idx;
    int           words;
    logic [W-1:0] exp_w;
    rst = 1'b1; mon_msg_en = '0; mon_msg = '0; out_msg_ready = 1'b0;
    host_ack_valid = 1'b0; host_ack_app_id = '0; host_ack_type = '0; rearm_all = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_valid", out_msg_valid, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_arm", {arm_cong_monitor, arm_scale_down_monitor}, 0);
    rst = 1'b0;

    // Single congestion strobe from app 1, latency T+2.
    out_msg_ready = 1'b1;
    strobe(1, NIC_MSG_CONG_HINT, 16'h1);
    tick();
    chk("lat_t1_valid", out_msg_valid, 0);
    tick();
    chk("lat_t2_valid", out_msg_valid, 1);
    exp_w = {NIC_MSG_CONG_HINT, 2'd1, 16'h0001};
    chk("lat_t2_msg", out_msg, exp_w);
    tick();
    chk("lat_level0", fifo_level, 0);

    // All slots strobed (scale-down then congestion) from rr_ptr=0: slot order 0..7.
    do_reset();
    out_msg_ready = 1'b1;
    for (int a = 0; a < N; a++) strobe(a, NIC_MSG_SCALE_DOWN_HINT, 16'(16'h100 + 2 * a));
    tick();
    for (int a = 0; a < N; a++) strobe(a, NIC_MSG_CONG_HINT, 16'(16'h100 + 2 * a + 1));
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (out_msg_valid) begin
        chk("order_word", out_msg, slot_word(idx, 16'(16'h100 + idx)));
        idx++;
      end
    end
    chk("order_count", idx, NSLOT);
    chk("order_drop", drop_count, 0);

    // Stall with more messages than FIFO entries; head must stay put.
    do_reset();
    out_msg_ready = 1'b0;
    for (int a = 0; a < N; a++) strobe(a, NIC_MSG_SCALE_DOWN_HINT, 16'(16'h100 + 2 * a));
    tick();
    for (int a = 0; a < N; a++) strobe(a, NIC_MSG_CONG_HINT, 16'(16'h100 + 2 * a + 1));
    tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("stall_head", out_msg, slot_word(0, 16'h100));
    end
    chk("stall_full", fifo_level, DEPTH);

    // Unknown type plus a duplicate on pending slot 5 (FIFO full, so no grant).
    strobe(0, 4'hF, 16'h1234);
    strobe(2, NIC_MSG_CONG_HINT, 16'hBEEF);
    tick();
    chk("drop_two", drop_count, 2);

    out_msg_ready = 1'b1;
    words = 0;
    for (int c = 0; c < 14; c++) begin
      if (out_msg_valid && out_msg_ready) begin
        words++;
        if (out_msg[W-1 -: 6] == {NIC_MSG_CONG_HINT, 2'd2})
          chk("dup_kept", out_msg[15:0], 16'h105);
      end
      tick();
    end
    chk("drain_count", words, NSLOT);
    chk("drain_level", fifo_level, 0);

    // Capture and grant on the same slot in the same cycle.
    strobe(1, NIC_MSG_CONG_HINT, 16'hA1);
    tick();
    strobe(1, NIC_MSG_CONG_HINT, 16'hA2);
    tick();
    exp_w = {NIC_MSG_CONG_HINT, 2'd1, 16'h00A1};
    chk("same_first", out_msg, exp_w);
    chk("same_nodrop", drop_count, 2);
    tick();
    exp_w = {NIC_MSG_CONG_HINT, 2'd1, 16'h00A2};
    chk("same_second", out_msg, exp_w);
    tick(); tick();

    // Ack and rearm pulses.
    host_ack_valid = 1'b1; host_ack_app_id = 2'd2; host_ack_type = NIC_MSG_CONG_HINT;
    tick();
    chk("ack_cong", arm_cong_monitor, 4'b0100);
    chk("ack_sd", arm_scale_down_monitor, 4'b0000);
    tick();
    chk("ack_width", arm_cong_monitor, 4'b0000);
    rearm_all = 1'b1;
    host_ack_valid = 1'b1; host_ack_app_id = 2'd1; host_ack_type = 4'h7;
    tick();
    chk("rearm_cong", arm_cong_monitor, 4'hF);
    chk("rearm_sd", arm_scale_down_monitor, 4'hF);
    tick();
    chk("rearm_width", {arm_cong_monitor, arm_scale_down_monitor}, 0);

    // Reset with 3 queued entries and 2 pending slots.
    do_reset();
    out_msg_ready = 1'b0;
    for (int a = 0; a < 3; a++) strobe(a, NIC_MSG_SCALE_DOWN_HINT, 16'(16'h200 + a));
    tick(); tick(); tick(); tick();
    chk("pre_rst_level", fifo_level, 3);
    strobe(0, NIC_MSG_CONG_HINT, 16'h300);
    strobe(1, NIC_MSG_CONG_HINT, 16'h301);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_msg_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    rst = 1'b0;
    out_msg_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_quiet", out_msg_valid, 0);
    end

    // Random phase.
    for (int c = 0; c < 800; c++) begin
      int r;
      for (int a = 0; a < N; a++) begin
        if ($urandom_range(0, 9) < 3) begin
          r = $urandom_range(0, 19);
          strobe(a, (r < 9) ? NIC_MSG_SCALE_DOWN_HINT :
                    (r < 18) ? NIC_MSG_CONG_HINT : 4'($urandom_range(3, 15)),
                 16'($urandom));
        end
      end
      out_msg_ready   = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      host_ack_valid  = ($urandom_range(0, 4) == 0);
      host_ack_app_id = 2'($urandom);
      host_ack_type   = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                        ($urandom_range(0, 1) == 0) ? NIC_MSG_CONG_HINT : NIC_MSG_SCALE_DOWN_HINT;
      rearm_all       = ($urandom_range(0, 19) == 0);
      rst             = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
